// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op-code field width and the
// op-code values understood by the shared ALU and its arbiter.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by all requesters.
// Ports:
//   a, b    - operands
//   op      - op code (alu_op_e)
//   result  - ALU result, wrap-around arithmetic
//   zero    - high when result is all zeros
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // One 33-bit subtractor serves SUB, SLT (bit 31) and SLTU (borrow bit 32).
  logic [DATA_W:0] diff_ext;

  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = diff_ext[DATA_W-1:0];
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, diff_ext[DATA_W-1]};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, diff_ext[DATA_W]};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - per-requester request bits
//   ptr   - index of the most recently granted requester
//   grant - one-hot grant (zero when no request); scanning starts at ptr+1
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      // (ptr + k) mod N_REQ; one conditional subtract is enough since
      // ptr < N_REQ and k <= N_REQ.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters with round-robin arbitration, an
// optional bounded lock, and a one-entry registered response buffer.
// Ports:
//   Clk, Reset_n           - clock (rising edge), async active-low reset
//   Req_Valid/Req_Ready    - per-requester request handshake (Ready one-hot or 0)
//   Req_A/Req_B/Req_Op     - packed operands/op, requester i at slice i
//   Req_Lock               - keep the grant after this accept
//   Rsp_Valid/Rsp_Ready    - one-hot response valid, per-requester consume
//   Rsp_Result, Rsp_Zero   - registered ALU result and zero flag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int LOCK_MAX = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [N_REQ-1:0]        Req_Valid,
  output logic [N_REQ-1:0]        Req_Ready,
  input  logic [DATA_W*N_REQ-1:0] Req_A,
  input  logic [DATA_W*N_REQ-1:0] Req_B,
  input  logic [OP_W*N_REQ-1:0]   Req_Op,
  input  logic [N_REQ-1:0]        Req_Lock,
  output logic [N_REQ-1:0]        Rsp_Valid,
  input  logic [N_REQ-1:0]        Rsp_Ready,
  output logic [DATA_W-1:0]       Rsp_Result,
  output logic                    Rsp_Zero
);

  localparam int             PW       = $clog2(N_REQ);
  localparam logic [3:0]     LOCK_LIM = 4'(LOCK_MAX);

  // Response buffer
  logic [N_REQ-1:0]  rsp_vld_p1;
  logic [DATA_W-1:0] rsp_result_p1;
  logic              rsp_zero_p1;

  // Arbitration state
  logic [PW-1:0]     last_grant;
  logic              lock_vld;
  logic [PW-1:0]     lock_owner;
  logic [3:0]        lock_cnt;

  logic [N_REQ-1:0]  rr_grant;
  logic [N_REQ-1:0]  win_oh;
  logic [N_REQ-1:0]  req_ready;
  logic [PW-1:0]     win_idx;
  logic              win_lock;
  logic              owner_valid;
  logic              drain;
  logic              slot_free;
  logic              accept;
  logic [3:0]        cnt_inc;

  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [OP_W-1:0]   op_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req   (Req_Valid),
    .ptr   (last_grant),
    .grant (rr_grant)
  );

  // Stage p0: winner selection and operand mux
  assign owner_valid = lock_vld & Req_Valid[lock_owner];
  assign drain       = |(rsp_vld_p1 & Rsp_Ready);
  assign slot_free   = ~|rsp_vld_p1 | drain;

  always_comb begin
    win_oh = rr_grant;
    if (owner_valid) begin
      win_oh             = '0;
      win_oh[lock_owner] = 1'b1;
    end
  end

  // Gating with Reset_n keeps Ready low for the whole reset, even though the
  // empty buffer would otherwise report a free slot.
  assign req_ready = win_oh & {N_REQ{slot_free & Reset_n}};
  assign accept    = |(Req_Valid & req_ready);

  always_comb begin
    win_idx  = '0;
    win_lock = 1'b0;
    a_sel    = '0;
    b_sel    = '0;
    op_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = PW'(i);
        win_lock = Req_Lock[i];
        a_sel    = Req_A[i*DATA_W +: DATA_W];
        b_sel    = Req_B[i*DATA_W +: DATA_W];
        op_sel   = Req_Op[i*OP_W +: OP_W];
      end
    end
  end

  alu u_alu (
    .a      (a_sel),
    .b      (b_sel),
    .op     (op_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // A lock taken by a new owner starts counting from one.
  assign cnt_inc = ((lock_vld && (lock_owner == win_idx)) ? lock_cnt : 4'd0) + 4'd1;

  // Stage p1: response buffer
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_vld_p1    <= '0;
      rsp_result_p1 <= '0;
      rsp_zero_p1   <= 1'b0;
    end else if (accept) begin
      rsp_vld_p1    <= win_oh;
      rsp_result_p1 <= alu_result;
      rsp_zero_p1   <= alu_zero;
    end else if (drain) begin
      rsp_vld_p1    <= '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant <= PW'(N_REQ - 1);
      lock_vld   <= 1'b0;
      lock_owner <= '0;
      lock_cnt   <= '0;
    end else if (accept) begin
      last_grant <= win_idx;
      // The watchdog bound wins over a still-asserted Req_Lock.
      if (win_lock && (cnt_inc < LOCK_LIM)) begin
        lock_vld   <= 1'b1;
        lock_owner <= win_idx;
        lock_cnt   <= cnt_inc;
      end else begin
        lock_vld   <= 1'b0;
        lock_cnt   <= '0;
      end
    end else if (lock_vld && !Req_Valid[lock_owner]) begin
      lock_vld <= 1'b0;
      lock_cnt <= '0;
    end
  end

  assign Req_Ready  = req_ready;
  assign Rsp_Valid  = rsp_vld_p1;
  assign Rsp_Result = rsp_result_p1;
  assign Rsp_Zero   = rsp_zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int LM = 4;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [N-1:0]    Req_Valid;
  logic [N-1:0]    Req_Ready;
  logic [32*N-1:0] Req_A;
  logic [32*N-1:0] Req_B;
  logic [3*N-1:0]  Req_Op;
  logic [N-1:0]    Req_Lock;
  logic [N-1:0]    Rsp_Valid;
  logic [N-1:0]    Rsp_Ready;
  logic [31:0]     Rsp_Result;
  logic            Rsp_Zero;

  alu_arbiter #(.N_REQ(N), .LOCK_MAX(LM)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_A      (Req_A),
    .Req_B      (Req_B),
    .Req_Op     (Req_Op),
    .Req_Lock   (Req_Lock),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Result (Rsp_Result),
    .Rsp_Zero   (Rsp_Zero)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t tbl[13];

  // Reference model state
  int          m_ptr, m_pend, m_lown, m_lcnt;
  logic [31:0] m_res;
  logic        m_zero;
  logic [N-1:0] acc_prev;
  int          rr_count[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op, input logic lk);
    Req_Valid[i]     = v;
    Req_A[i*32 +: 32] = a;
    Req_B[i*32 +: 32] = b;
    Req_Op[i*3 +: 3]  = op;
    Req_Lock[i]      = lk;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] d;
    d = a - b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return d;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      3'd6:    return {31'b0, d[31]};
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom();
  endfunction

  // One randomized cycle: new stimulus, predicted Req_Ready, clock edge,
  // predicted response.
  task automatic rand_cycle();
    int          w;
    int          j;
    bit          slot;
    logic [N-1:0] exp_ready;
    logic [31:0] a, b;
    logic [2:0]  op;
    for (int i = 0; i < N; i++) begin
      if (!(Req_Valid[i] && !acc_prev[i])) begin
        set_req(i, ($urandom_range(0, 2) != 0), rnd_operand(), rnd_operand(),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      Rsp_Ready[i] = ($urandom_range(0, 3) != 0);
    end
    #1;
    w = -1;
    if (m_lown >= 0 && ((Req_Valid >> m_lown) & 1) != 0) begin
      w = m_lown;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && ((Req_Valid >> j) & 1) != 0) w = j;
      end
    end
    slot      = (m_pend < 0) || (((Rsp_Ready >> m_pend) & 1) != 0);
    exp_ready = (w >= 0 && slot) ? (N'(1) << w) : '0;
    chk("rand_req_ready", 32'(Req_Ready), 32'(exp_ready));
    if (w >= 0 && slot) begin
      a      = Req_A[w*32 +: 32];
      b      = Req_B[w*32 +: 32];
      op     = Req_Op[w*3 +: 3];
      m_res  = ref_alu(a, b, op);
      m_zero = (m_res == 0);
      m_pend = w;
      m_ptr  = w;
      if (((Req_Lock >> w) & 1) != 0) begin
        m_lcnt = ((m_lown == w) ? m_lcnt : 0) + 1;
        if (m_lcnt >= LM) begin
          m_lown = -1;
          m_lcnt = 0;
        end else begin
          m_lown = w;
        end
      end else begin
        m_lown = -1;
        m_lcnt = 0;
      end
    end else begin
      if (m_pend >= 0 && slot) m_pend = -1;
      if (m_lown >= 0 && ((Req_Valid >> m_lown) & 1) == 0) begin
        m_lown = -1;
        m_lcnt = 0;
      end
    end
    acc_prev = exp_ready;
    @(posedge Clk);
    #1;
    chk("rand_rsp_valid", 32'(Rsp_Valid), (m_pend >= 0) ? (32'd1 << m_pend) : 32'd0);
    chk("rand_rsp_result", Rsp_Result, m_res);
    chk("rand_rsp_zero", 32'(Rsp_Zero), 32'(m_zero));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{32'd5,          32'd7,          3'd0, 32'd12,         1'b0};
    tbl[1]  = '{32'd7,          32'd7,          3'd1, 32'd0,          1'b1};
    tbl[2]  = '{32'hF0F0F0F0,   32'hFF00FF00,   3'd2, 32'hF000F000,   1'b0};
    tbl[3]  = '{32'hF0F0F0F0,   32'hFF00FF00,   3'd3, 32'hFFF0FFF0,   1'b0};
    tbl[4]  = '{32'hF0F0F0F0,   32'hFF00FF00,   3'd4, 32'h0FF00FF0,   1'b0};
    tbl[5]  = '{32'h0F0F0F0F,   32'h00000000,   3'd5, 32'hF0F0F0F0,   1'b0};
    tbl[6]  = '{32'hFFFFFFFF,   32'd1,          3'd6, 32'd1,          1'b0};
    tbl[7]  = '{32'hFFFFFFFF,   32'd1,          3'd7, 32'd0,          1'b1};
    tbl[8]  = '{32'h80000000,   32'd0,          3'd0, 32'h80000000,   1'b0};
    tbl[9]  = '{32'd0,          32'd1,          3'd1, 32'hFFFFFFFF,   1'b0};
    tbl[10] = '{32'hFFFFFFFF,   32'd1,          3'd0, 32'd0,          1'b1};
    tbl[11] = '{32'd1,          32'd2,          3'd6, 32'd1,          1'b0};
    tbl[12] = '{32'd1,          32'd2,          3'd7, 32'd1,          1'b0};

    Req_Valid = '0; Req_A = '0; Req_B = '0; Req_Op = '0; Req_Lock = '0;
    Rsp_Ready = '0;

    // Reset state, with every requester knocking
    Reset_n   = 1'b0;
    Req_Valid = '1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req_ready", 32'(Req_Ready), 32'd0);
    chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("rst_rsp_result", Rsp_Result, 32'd0);
    chk("rst_rsp_zero", 32'(Rsp_Zero), 32'd0);
    Req_Valid = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    // Table of ALU vectors through requester 0, consumer always ready
    Rsp_Ready = '1;
    for (int v = 0; v < 13; v++) begin
      set_req(0, 1'b1, tbl[v].a, tbl[v].b, tbl[v].op, 1'b0);
      #1;
      chk("tbl_req_ready", 32'(Req_Ready), 32'd1);
      tick();
      chk("tbl_rsp_valid", 32'(Rsp_Valid), 32'd1);
      chk("tbl_rsp_result", Rsp_Result, tbl[v].res);
      chk("tbl_rsp_zero", 32'(Rsp_Zero), 32'(tbl[v].zero));
    end
    Req_Valid = '0;
    tick();
    chk("tbl_drain", 32'(Rsp_Valid), 32'd0);

    // Round-robin with everyone valid; last grant was requester 0
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 32'(100 * i), 32'(i), 3'd0, 1'b0);
      rr_count[i] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_rsp_valid", 32'(Rsp_Valid), 32'd1 << ((1 + k) % N));
      chk("rr_rsp_result", Rsp_Result, 32'(101 * ((1 + k) % N)));
      for (int i = 0; i < N; i++) if (Rsp_Valid[i]) rr_count[i]++;
    end
    for (int i = 0; i < N; i++) chk("rr_share", 32'(rr_count[i]), 32'd2);
    Req_Valid = '0;
    tick();

    // Backpressure on requester 1, then drain and accept on the same edge
    Rsp_Ready = '0;
    set_req(1, 1'b1, 32'd11, 32'd22, 3'd0, 1'b0);
    tick();
    chk("bp_rsp_valid", 32'(Rsp_Valid), 32'b0010);
    chk("bp_rsp_result", Rsp_Result, 32'd33);
    Req_Valid[1] = 1'b0;
    set_req(2, 1'b1, 32'd40, 32'd2, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req_ready_stall", 32'(Req_Ready), 32'd0);
      tick();
      chk("bp_hold_valid", 32'(Rsp_Valid), 32'b0010);
      chk("bp_hold_result", Rsp_Result, 32'd33);
    end
    Rsp_Ready = 4'b0010;
    #1;
    chk("bp_req_ready_drain", 32'(Req_Ready), 32'b0100);
    tick();
    chk("bp_next_valid", 32'(Rsp_Valid), 32'b0100);
    chk("bp_next_result", Rsp_Result, 32'd38);
    Req_Valid = '0;
    Rsp_Ready = '1;
    tick();

    // Lock bound: req0 locked against req1; last grant was requester 2
    set_req(0, 1'b1, 32'd1, 32'd1, 3'd0, 1'b1);
    set_req(1, 1'b1, 32'd2, 32'd2, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("lock_bound", 32'(Rsp_Valid), (k < LM) ? 32'b0001 : 32'b0010);
    end
    // req0 relocks, then drops valid: lock must be released
    tick();
    chk("lock_relock0", 32'(Rsp_Valid), 32'b0001);
    tick();
    chk("lock_relock1", 32'(Rsp_Valid), 32'b0001);
    Req_Valid = '0;
    tick();
    chk("lock_drop_idle", 32'(Rsp_Valid), 32'd0);
    Req_Valid = 4'b0011;
    tick();
    chk("lock_released", 32'(Rsp_Valid), 32'b0010);
    Req_Valid = '0;
    tick();

    // Reset mid-stream with a pending result for requester 2
    Rsp_Ready = '0;
    set_req(2, 1'b1, 32'd3, 32'd4, 3'd0, 1'b0);
    tick();
    chk("mid_pending", 32'(Rsp_Valid), 32'b0100);
    set_req(0, 1'b1, 32'd10, 32'd20, 3'd0, 1'b0);
    set_req(3, 1'b1, 32'd1, 32'd1, 3'd0, 1'b0);
    Req_Valid[2] = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(Rsp_Valid), 32'd0);
    chk("mid_rst_result", Rsp_Result, 32'd0);
    chk("mid_rst_zero", 32'(Rsp_Zero), 32'd0);
    chk("mid_rst_ready", 32'(Req_Ready), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(Req_Ready), 32'b0001);
    tick();
    chk("post_rst_valid", 32'(Rsp_Valid), 32'b0001);
    chk("post_rst_result", Rsp_Result, 32'd30);

    // Randomized run against the reference model, from a fresh reset
    Req_Valid = '0;
    Req_Lock  = '0;
    Reset_n   = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    m_ptr = N - 1; m_pend = -1; m_lown = -1; m_lcnt = 0;
    m_res = '0; m_zero = 1'b0; acc_prev = '0;
    for (int c = 0; c < 400; c++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
